// File: rtl/mem_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : mem_fetch_seq
// Brief    : Burst fetch sequencer in front of an asynchronous read-only memory.
//            Drives addr and captures memData into a registered valid/ready
//            stream. Optional macro FETCH_CHECKSUM_EN adds an XOR checksum port.
// Revision : 1.0
// ============================================================================
module mem_fetch_seq #(
    parameter  int DATA_LENGTH = 32,
    parameter  int MEM_SIZE    = 256,
    localparam int ADDR_WIDTH  = $clog2(MEM_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  baseAddr,
    input  logic [ADDR_WIDTH:0]    len,
    output logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_LENGTH-1:0] memData,
    output logic [DATA_LENGTH-1:0] dataOut,
    output logic                   valid,
    input  logic                   ready,
    output logic                   busy,
    output logic                   done
`ifdef FETCH_CHECKSUM_EN
    ,
    output logic [DATA_LENGTH-1:0] checksum
`endif
);

    localparam logic [ADDR_WIDTH:0]   c_MEM_WORDS = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH:0]     r_remaining;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_LENGTH-1:0]  r_data;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_done;

    logic [ADDR_WIDTH:0]     w_len_clamped;
    logic [ADDR_WIDTH-1:0]   w_addr_next;
    logic                    w_xfer;
    logic                    w_load_slot;
    logic                    w_start_ok;

    // Clamping keeps a burst from ever revisiting a word.
    assign w_len_clamped = (len > c_MEM_WORDS) ? c_MEM_WORDS : len;
    assign w_addr_next   = (r_addr == c_LAST_ADDR) ? '0 : r_addr + 1'b1;
    assign w_xfer        = r_valid & ready;
    assign w_load_slot   = ~r_valid | ready;
    assign w_start_ok    = (r_state == S_IDLE) & start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_len_clamped != '0) begin
                            r_addr      <= baseAddr;
                            r_remaining <= w_len_clamped;
                            r_state     <= S_FETCH;
                            r_busy      <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    // A load both refills the output register and retires the word it replaces.
                    if (w_load_slot) begin
                        r_data      <= memData;
                        r_valid     <= 1'b1;
                        r_addr      <= w_addr_next;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == (ADDR_WIDTH+1)'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_xfer) begin
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_CHECKSUM_EN
    logic [DATA_LENGTH-1:0] r_checksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_checksum <= r_checksum ^ r_data;
        end
    end

    assign checksum = r_checksum;
`else
    logic w_unused_start_ok;
    assign w_unused_start_ok = w_start_ok;
`endif

    assign addr    = r_addr;
    assign dataOut = r_data;
    assign valid   = r_valid;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: doc/mem_fetch_seq.md
Name: mem_fetch_seq

Overview:
- Sequencer that sits directly upstream of the asynchronous read-only memory.
- Drives the memory's addr input and captures its combinational dataOut into a registered valid/ready output stream.
- Fetches a programmed burst of consecutive words, starting at a base address.
- Feeds later pipeline stages (e.g. an instruction/operand consumer) at one word per clock when not back-pressured.

Parameters:
- DATA_LENGTH, 32, width of one memory word.
- MEM_SIZE, 256, number of words in the attached memory.
- ADDR_WIDTH, $clog2(MEM_SIZE), derived localparam (8 at defaults); not overridable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- baseAddr  input  ADDR_WIDTH  first word address; sampled with start.
- len  input  ADDR_WIDTH+1  number of words in the burst, 0..MEM_SIZE; sampled with start.
- addr  output  ADDR_WIDTH  address to memory; registered.
- memData  input  DATA_LENGTH  memory dataOut; combinational function of addr.
- dataOut  output  DATA_LENGTH  registered word to consumer.
- valid  output  1  dataOut holds an unconsumed word.
- ready  input  1  consumer accepts dataOut this cycle when valid=1.
- busy  output  1  burst in progress (not IDLE).
- done  output  1  one-cycle pulse after the last word of a burst is consumed.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: addr=0, dataOut=0, valid=0, busy=0, done=0, state=IDLE, internal remaining counter=0.
- Reset mid-burst aborts the burst immediately. No done pulse is issued, and no stale valid remains after reset.
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - start=1 and len>0: latch addr<=baseAddr and remaining<=len; go to FETCH; busy=1 from next cycle.
  - start=1 and len=0: stay IDLE; pulse done=1 the next cycle; no words emitted.
- FETCH:
  - A load slot exists when valid=0 or (valid=1 and ready=1).
  - On a load slot:
    - dataOut<=memData (the word at the current addr).
    - valid<=1.
    - addr<=addr+1, wrapping from MEM_SIZE-1 to 0 (modulo 2^ADDR_WIDTH at power-of-two MEM_SIZE).
    - remaining<=remaining-1.
  - When the load uses the last word (remaining==1), go to DRAIN.
  - Without a load slot (valid=1, ready=0), dataOut, addr and remaining hold.
- DRAIN:
  - Waits for the final word to be taken.
  - On valid&&ready: valid<=0, done<=1 next cycle, state<=IDLE, busy<=0.
- Timing:
  - Latency from start to first valid=1 is 2 cycles.
  - With ready held high, throughput is 1 word/cycle.
- Handshake rules:
  - A word transfers on any rising edge with valid&&ready.
  - dataOut is stable while valid=1 and ready=0.
  - valid never drops without a transfer, except on reset.
- start while busy=1 is ignored.
- start in the same cycle as done is high is accepted; this is legal because the state is IDLE.
- len>MEM_SIZE is clamped to MEM_SIZE; words are never re-read within a burst.
- addr after a burst equals baseAddr+len mod MEM_SIZE, left unchanged until the next start.
- done is high for exactly one cycle per accepted start.

Optional Feature:
- Macro: FETCH_CHECKSUM_EN.
- Defined:
  - Adds output port checksum, DATA_LENGTH wide, reset 0.
  - checksum clears to 0 on an accepted start.
  - It XOR-accumulates every word on each valid&&ready transfer.
  - Its final value is stable from the done pulse until the next accepted start.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Bench memory model: mem[a]=32'h1000+a. Reset asserted at 0, released at 15.
- Basic burst: start, baseAddr=8'd0, len=3, ready=1 -> valid high on 3 consecutive cycles with dataOut 32'h1000, 32'h1001, 32'h1002; done pulses once 1 cycle after the last transfer; final addr=3.
- Backpressure: baseAddr=8'd10, len=4, ready low 3 cycles after the first valid -> dataOut holds 32'h100A throughout the stall; sequence 100A..100D is delivered with no loss or duplication.
- Wrap-around: baseAddr=8'd254, len=4 -> words 32'h10FE, 32'h10FF, 32'h1000, 32'h1001; final addr=2.
- Zero length and ignored start:
  - len=0 -> no valid; done pulses 1 cycle after start.
  - A second start during a busy burst -> the first burst completes unchanged and only one done pulse is issued.
- Async reset mid-burst: assert rst between clock edges after 2 of 5 words -> valid, busy, done and addr go to 0 immediately, without waiting for a clock edge; a subsequent burst (baseAddr=8'd5, len=2) delivers 32'h1005, 32'h1006.
- With FETCH_CHECKSUM_EN: burst baseAddr=0, len=3 -> checksum = 32'h1000^32'h1001^32'h1002 = 32'h1003 at done.
